uart_autobaud_tx: RTL and testbench

//  UART transmitter paired with the adaptive (auto-baud) UART receiver. Serialises 8N1 bytes at a
//  run-time divisor and, on request, sends a burst of SYNC_CHAR calibration characters.
//  The far-end adaptive receiver measures its bit width from that burst.

---
 rtl/uart_autobaud_tx_pkg.sv | 32 +++
 rtl/uart_autobaud_tx_bit_timer.sv | 35 +++
 rtl/uart_autobaud_tx.sv | 210 +++++++++++++++++++++
 tb/tb_uart_autobaud_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_autobaud_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_autobaud_tx_pkg
// Description : Shared definitions for the auto-baud UART transmitter:
//               FSM state encoding, default calibration character and
//               frame-length constants (8N1 / 8E1).
//               Build option: UART_TX_PARITY_EN selects 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_autobaud_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_t;

  localparam logic [7:0] SYNC_CHAR_DEFAULT = 8'h55;

  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_8E1;
`else
  localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

endpackage
`default_nettype wire

// File: rtl/uart_autobaud_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Bit-period timer. While disabled it preloads div-1; while
//               enabled it counts down and raises bit_tick on the last clock
//               of each bit, reloading div-1 so every bit lasts div clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt;

  assign bit_tick = en & (cnt == '0);

  // Count down one bit period; preload whenever idle or at a bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || (cnt == '0)) begin
      cnt <= div - 1'b1;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_autobaud_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_autobaud_tx
// Description : UART transmitter with run-time baud divisor and a sync-burst
//               mode that sends SYNC_CNT x SYNC_CHAR for a far-end auto-baud
//               receiver. Divisor writes while busy are deferred to IDLE.
//               Build option: UART_TX_PARITY_EN adds an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_autobaud_tx
  import uart_autobaud_tx_pkg::*;
#(
  parameter int         DIV_W       = 16,
  parameter int         DEFAULT_DIV = 434,
  parameter int         MIN_DIV     = 4,
  parameter logic [7:0] SYNC_CHAR   = SYNC_CHAR_DEFAULT,
  parameter int         SYNC_CNT    = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_div_vld,
  input  logic [DIV_W-1:0] i_div_data,
  input  logic             i_sync_req,
  input  logic             i_tx_vld,
  input  logic [7:0]       i_tx_data,
  output logic             o_tx_rdy,
  output logic             o_uart_tx,
  output logic             o_busy,
  output logic             o_sync_done
);

  localparam int               SCNT_W    = $clog2(SYNC_CNT + 1);
  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEFAULT_DIV);
  localparam logic [3:0]       LAST_POS  = 4'(FRAME_BITS - 1);

  tx_state_t         state;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  div_pend;
  logic              div_pend_vld;
  logic [DIV_W-1:0]  div_wr;
  logic [DIV_W-1:0]  div_eff;
  logic              sync_pend;
  logic              in_sync;
  logic [SCNT_W-1:0] sync_left;
  logic [7:0]        shreg;      // LSB is the next data bit to go out
  logic [3:0]        bit_pos;    // frame position of the bit on the line
  logic              line;
  logic              sync_done;
  logic              bit_tick;
  logic              accept;
  logic              sync_want;
`ifdef UART_TX_PARITY_EN
  logic              parity;
`endif

  assign div_wr    = (i_div_data < MIN_DIV_V) ? MIN_DIV_V : i_div_data;
  // A write in IDLE must already govern a frame launched in the same cycle.
  assign div_eff   = ((state == ST_IDLE) && i_div_vld) ? div_wr : div;
  assign o_tx_rdy  = (state == ST_IDLE) & ~sync_pend & ~i_rst;
  assign accept    = i_tx_vld & o_tx_rdy;
  assign sync_want = sync_pend | i_sync_req;
  assign o_busy    = (state != ST_IDLE);
  assign o_uart_tx = line;
  assign o_sync_done = sync_done;

  uart_bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .en       (o_busy),
    .div      (div_eff),
    .bit_tick (bit_tick)
  );

  // Frame sequencer, shifter, sync-burst control and divisor bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      line         <= 1'b1;
      sync_done    <= 1'b0;
      div          <= DEF_DIV_V;
      div_pend     <= DEF_DIV_V;
      div_pend_vld <= 1'b0;
      sync_pend    <= 1'b0;
      in_sync      <= 1'b0;
      sync_left    <= '0;
      shreg        <= '0;
      bit_pos      <= '0;
`ifdef UART_TX_PARITY_EN
      parity       <= 1'b0;
`endif
    end else begin
      sync_done <= 1'b0;
      if (i_div_vld) begin
        if (state == ST_IDLE) begin
          div <= div_wr;
        end else begin
          div_pend     <= div_wr;
          div_pend_vld <= 1'b1;
        end
      end
      // Requests arriving during a burst are absorbed.
      if (i_sync_req && !in_sync) sync_pend <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          line <= 1'b1;
          if (accept) begin
            shreg   <= i_tx_data;
`ifdef UART_TX_PARITY_EN
            parity  <= ^i_tx_data;
`endif
            state   <= ST_START;
            line    <= 1'b0;
            bit_pos <= 4'd0;
          end else if (sync_want) begin
            in_sync   <= 1'b1;
            sync_pend <= 1'b0;
            sync_left <= SCNT_W'(SYNC_CNT);
            shreg     <= SYNC_CHAR;
`ifdef UART_TX_PARITY_EN
            parity    <= ^SYNC_CHAR;
`endif
            state     <= ST_START;
            line      <= 1'b0;
            bit_pos   <= 4'd0;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            line    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_pos <= bit_pos + 4'd1;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            bit_pos <= bit_pos + 4'd1;
            if (bit_pos == 4'd8) begin
`ifdef UART_TX_PARITY_EN
              line  <= parity;
              state <= ST_PAR;
`else
              line  <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              line  <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PAR: begin
          if (bit_tick) begin
            line    <= 1'b1;
            bit_pos <= bit_pos + 4'd1;
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick && (bit_pos == LAST_POS)) begin
            if (in_sync && (sync_left > SCNT_W'(1))) begin
              // next calibration character, back-to-back
              sync_left <= sync_left - SCNT_W'(1);
              shreg     <= SYNC_CHAR;
              state     <= ST_START;
              line      <= 1'b0;
              bit_pos   <= 4'd0;
            end else if (!in_sync && sync_want) begin
              // byte frame done, burst follows directly
              in_sync   <= 1'b1;
              sync_pend <= 1'b0;
              sync_left <= SCNT_W'(SYNC_CNT);
              shreg     <= SYNC_CHAR;
`ifdef UART_TX_PARITY_EN
              parity    <= ^SYNC_CHAR;
`endif
              state     <= ST_START;
              line      <= 1'b0;
              bit_pos   <= 4'd0;
            end else begin
              state   <= ST_IDLE;
              line    <= 1'b1;
              in_sync <= 1'b0;
              if (in_sync) sync_done <= 1'b1;
              if (i_div_vld) begin
                div          <= div_wr;
                div_pend_vld <= 1'b0;
              end else if (div_pend_vld) begin
                div          <= div_pend;
                div_pend_vld <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          line  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_autobaud_tx
// Description : Self-checking bench for uart_autobaud_tx. Each scenario fills
//               a per-cycle stimulus table and an expected line/busy/done
//               timeline built from frame arithmetic, then replays and
//               compares. Honours UART_TX_PARITY_EN for 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_autobaud_tx;
  import uart_autobaud_tx_pkg::*;

  localparam int         DIV_W       = 16;
  localparam int         DEFAULT_DIV = 434;
  localparam int         MIN_DIV     = 4;
  localparam logic [7:0] SYNC_CHAR   = 8'h55;
  localparam int         SYNC_CNT    = 2;
  localparam int         MAXN        = 8192;
  localparam int         FB          = FRAME_BITS;

  logic             clk = 1'b0;
  logic             rst;
  logic             div_vld;
  logic [DIV_W-1:0] div_data;
  logic             sync_req;
  logic             tx_vld;
  logic [7:0]       tx_data;
  logic             tx_rdy;
  logic             uart_tx;
  logic             busy;
  logic             sync_done;

  always #5 clk = ~clk;

  uart_autobaud_tx #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .MIN_DIV     (MIN_DIV),
    .SYNC_CHAR   (SYNC_CHAR),
    .SYNC_CNT    (SYNC_CNT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_div_vld   (div_vld),
    .i_div_data  (div_data),
    .i_sync_req  (sync_req),
    .i_tx_vld    (tx_vld),
    .i_tx_data   (tx_data),
    .o_tx_rdy    (tx_rdy),
    .o_uart_tx   (uart_tx),
    .o_busy      (busy),
    .o_sync_done (sync_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // per-cycle stimulus table
  bit               s_vld  [MAXN];
  logic [7:0]       s_data [MAXN];
  bit               s_dvld [MAXN];
  logic [DIV_W-1:0] s_div  [MAXN];
  bit               s_sync [MAXN];
  bit               s_rst  [MAXN];
  // expected timeline
  bit               e_line [MAXN];
  bit               e_busy [MAXN];
  bit               e_done [MAXN];
  int               e_n;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_div(input int v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < MAXN; i++) begin
      s_vld[i] = 0; s_data[i] = '0; s_dvld[i] = 0; s_div[i] = '0;
      s_sync[i] = 0; s_rst[i] = 0;
      e_line[i] = 1; e_busy[i] = 0; e_done[i] = 0;
    end
    e_n = 0;
  endtask

  task automatic add_bits(input bit b, input bit bsy, input int n);
    for (int i = 0; i < n; i++) begin
      e_line[e_n] = b;
      e_busy[e_n] = bsy;
      e_n++;
    end
  endtask

  task automatic add_idle(input int n);
    add_bits(1'b1, 1'b0, n);
  endtask

  // one character: start, 8 data LSB first, [even parity], stop
  task automatic add_frame(input logic [7:0] b, input int d);
    add_bits(1'b0, 1'b1, d);
    for (int i = 0; i < 8; i++) add_bits(b[i], 1'b1, d);
`ifdef UART_TX_PARITY_EN
    add_bits(^b, 1'b1, d);
`endif
    add_bits(1'b1, 1'b1, d);
  endtask

  task automatic add_burst(input int d);
    for (int i = 0; i < SYNC_CNT; i++) add_frame(SYNC_CHAR, d);
    e_done[e_n] = 1;
  endtask

  // Replay the stimulus table and compare against the expected timeline.
  task automatic run_sched(input string tag);
    int el, eb, er, ed;
    el = 0; eb = 0; er = 0; ed = 0;
    for (int k = 0; k < e_n; k++) begin
      @(negedge clk);
      rst      = s_rst[k];
      tx_vld   = s_vld[k];
      tx_data  = s_data[k];
      div_vld  = s_dvld[k];
      div_data = s_div[k];
      sync_req = s_sync[k];
      #1;
      if (uart_tx   !== e_line[k]) el++;
      if (busy      !== e_busy[k]) eb++;
      if (tx_rdy    !== (~e_busy[k] & ~s_rst[k])) er++;
      if (sync_done !== e_done[k]) ed++;
    end
    check_val({tag, "_line_errs"}, el, 0);
    check_val({tag, "_busy_errs"}, eb, 0);
    check_val({tag, "_rdy_errs"},  er, 0);
    check_val({tag, "_done_errs"}, ed, 0);
  endtask

  task automatic scen_byte(input logic [7:0] b, input int v);
    int d;
    clear_sched();
    d = clamp_div(v);
    s_dvld[0] = 1; s_div[0] = DIV_W'(v); s_vld[0] = 1; s_data[0] = b;
    add_idle(1); add_frame(b, d); add_idle(3);
    run_sched("byte");
  endtask

  task automatic scen_sync(input int v, input int jabs);
    int d, j;
    clear_sched();
    d = clamp_div(v);
    j = (jabs > SYNC_CNT*FB*d) ? SYNC_CNT*FB*d : jabs;
    s_dvld[0] = 1; s_div[0] = DIV_W'(v); s_sync[0] = 1;
    s_sync[j] = 1;
    add_idle(1); add_burst(d); add_idle(3);
    run_sched("sync");
  endtask

  task automatic scen_byte_sync(input logic [7:0] b, input int v, input int j);
    int d;
    clear_sched();
    d = clamp_div(v);
    s_dvld[0] = 1; s_div[0] = DIV_W'(v); s_vld[0] = 1; s_data[0] = b;
    s_sync[(j > FB*d) ? FB*d : j] = 1;
    add_idle(1); add_frame(b, d); add_burst(d); add_idle(3);
    run_sched("byte_sync");
  endtask

  task automatic scen_div(input logic [7:0] b1, input int v1, input int v2,
                          input int v3, input logic [7:0] b2, input int j1);
    int d1, j;
    clear_sched();
    d1 = clamp_div(v1);
    j  = (j1 < 1) ? 1 : ((j1 > FB*d1-1) ? FB*d1-1 : j1);
    s_dvld[0] = 1; s_div[0] = DIV_W'(v1); s_vld[0] = 1; s_data[0] = b1;
    s_dvld[j] = 1; s_div[j] = DIV_W'(v2);
    s_dvld[j+1] = 1; s_div[j+1] = DIV_W'(v3);
    add_idle(1); add_frame(b1, d1);
    s_vld[e_n] = 1; s_data[e_n] = b2;
    add_idle(1); add_frame(b2, clamp_div(v3)); add_idle(3);
    run_sched("div_change");
  endtask

  task automatic scen_b2b(input logic [7:0] b1, input logic [7:0] b2, input int v);
    int d;
    clear_sched();
    d = clamp_div(v);
    s_dvld[0] = 1; s_div[0] = DIV_W'(v);
    for (int k = 0; k <= FB*d + 1; k++) begin
      s_vld[k] = 1; s_data[k] = (k == 0) ? b1 : b2;
    end
    add_idle(1); add_frame(b1, d); add_idle(1); add_frame(b2, d); add_idle(3);
    run_sched("back2back");
  endtask

  task automatic scen_reset(input logic [7:0] b, input int v, input logic [7:0] b2,
                            input int roff);
    int d, r;
    clear_sched();
    d = clamp_div(v);
    r = 1 + 4*d + (roff % d);
    s_dvld[0] = 1; s_div[0] = DIV_W'(v); s_vld[0] = 1; s_data[0] = b;
    s_sync[2] = 1;
    s_dvld[3] = 1; s_div[3] = DIV_W'(d + 7);
    s_rst[r] = 1;
    add_idle(1); add_frame(b, d);
    e_n = r + 1;
    add_idle(40);
    s_vld[e_n] = 1; s_data[e_n] = b2;
    add_idle(1); add_frame(b2, DEFAULT_DIV); add_idle(3);
    run_sched("reset_mid");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b1, b2;
    int kind;
    rst = 1'b1; div_vld = 1'b0; div_data = '0; sync_req = 1'b0;
    tx_vld = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_rdy",  int'(tx_rdy),    0);
    check_val("rst_line", int'(uart_tx),   1);
    check_val("rst_busy", int'(busy),      0);
    check_val("rst_done", int'(sync_done), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("post_rst_rdy", int'(tx_rdy), 1);

    scen_byte(8'hA5, 16);
    scen_sync(8, 30);
    scen_div(8'h5A, 16, 40, 32, 8'hC3, 50);
    scen_byte(8'h11, 2);
    scen_byte_sync(8'h3C, 10, 0);
    scen_byte(8'h07, 6);
    scen_b2b(8'h81, 8'h7E, 5);

    for (int it = 0; it < 30; it++) begin
      kind = int'($urandom_range(0, 4));
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      case (kind)
        0: scen_byte(b1, int'($urandom_range(0, 20)));
        1: scen_sync(int'($urandom_range(0, 12)), int'($urandom_range(2, 400)));
        2: scen_byte_sync(b1, int'($urandom_range(0, 12)), int'($urandom_range(0, 200)));
        3: scen_div(b1, int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 20)), b2, int'($urandom_range(1, 200)));
        default: scen_b2b(b1, b2, int'($urandom_range(0, 20)));
      endcase
    end

    scen_reset(8'hE7, 12, 8'h96, int'($urandom_range(0, 11)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
